// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU control unit: FSM state encoding,
// opcode map, ALU operation codes and branch-condition handling.
package cpu_pkg;

    // FSM states; the numeric values are visible on the debug state port.
    typedef enum logic [3:0] {
        ST_RESET   = 4'd0,
        ST_FETCH   = 4'd1,
        ST_DECODE  = 4'd2,
        ST_ALU_EX  = 4'd3,
        ST_LD_EX   = 4'd4,
        ST_ST_EX   = 4'd5,
        ST_LDI_EX  = 4'd6,
        ST_BR_EX   = 4'd7,
        ST_JMP_EX  = 4'd8,
        ST_HALT    = 4'd9,
        ST_ILLEGAL = 4'd10
    } state_e;

    // Opcode field is ir[15:9]; ALU ops occupy 0x10-0x1F with the op in ir[12:9].
    localparam logic [6:0] OP_NOP  = 7'h00;
    localparam logic [6:0] OP_LD   = 7'h20;
    localparam logic [6:0] OP_ST   = 7'h21;
    localparam logic [6:0] OP_LDI  = 7'h22;
    localparam logic [6:0] OP_BRA  = 7'h30;
    localparam logic [6:0] OP_BEQ  = 7'h31;
    localparam logic [6:0] OP_BNE  = 7'h32;
    localparam logic [6:0] OP_BMI  = 7'h33;
    localparam logic [6:0] OP_BCS  = 7'h34;
    localparam logic [6:0] OP_JMP  = 7'h38;
    localparam logic [6:0] OP_HALT = 7'h7F;

    // ALU op that forwards the S operand unchanged.
    localparam logic [3:0] ALU_PASS_S = 4'h0;

    // Branch-condition select produced by the decoder.
    typedef enum logic [2:0] {
        BC_NONE   = 3'd0,
        BC_ALWAYS = 3'd1,
        BC_EQ     = 3'd2,
        BC_NE     = 3'd3,
        BC_MI     = 3'd4,
        BC_CS     = 3'd5
    } br_cond_e;

    // Latched ALU flags, packed as {N,Z,C}.
    typedef struct packed {
        logic n;
        logic z;
        logic c;
    } status_t;

    // Evaluate a branch condition against the latched status flags.
    function automatic logic br_taken(br_cond_e cond, status_t st);
        logic taken;
        case (cond)
            BC_ALWAYS: taken = 1'b1;
            BC_EQ:     taken = st.z;
            BC_NE:     taken = ~st.z;
            BC_MI:     taken = st.n;
            BC_CS:     taken = st.c;
            default:   taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/cpu_cu_decode.sv
// Combinational opcode decoder: maps the opcode to the state entered after
// DECODE, the branch condition to evaluate and whether the opcode is legal.
module cpu_cu_decode
    import cpu_pkg::*;
(
    input  logic [6:0] opcode,
    output state_e     exec_state,
    output br_cond_e   br_cond,
    output logic       legal
);

    // Opcode classification; NOP and not-taken branches return to FETCH.
    always_comb begin
        // NOTE: every output gets a default first so no path through the
        // case leaves a signal unassigned, which would infer a latch.
        exec_state = ST_ILLEGAL;
        br_cond    = BC_NONE;
        legal      = 1'b1;
        if (opcode[6:4] == 3'b001) begin
            exec_state = ST_ALU_EX;
        end else begin
            case (opcode)
                OP_NOP:  exec_state = ST_FETCH;
                OP_LD:   exec_state = ST_LD_EX;
                OP_ST:   exec_state = ST_ST_EX;
                OP_LDI:  exec_state = ST_LDI_EX;
                OP_JMP:  exec_state = ST_JMP_EX;
                OP_HALT: exec_state = ST_HALT;
                OP_BRA: begin
                    exec_state = ST_BR_EX;
                    br_cond    = BC_ALWAYS;
                end
                OP_BEQ: begin
                    exec_state = ST_BR_EX;
                    br_cond    = BC_EQ;
                end
                OP_BNE: begin
                    exec_state = ST_BR_EX;
                    br_cond    = BC_NE;
                end
                OP_BMI: begin
                    exec_state = ST_BR_EX;
                    br_cond    = BC_MI;
                end
                OP_BCS: begin
                    exec_state = ST_BR_EX;
                    br_cond    = BC_CS;
                end
                default: begin
                    exec_state = ST_ILLEGAL;
                    legal      = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/cpu_cu.sv
// Moore control unit for the 16-bit CPU: sequences fetch/decode/execute,
// latches the {N,Z,C} status used by conditional branches and drives the
// execution-unit controls and memory strobes from the current state.
module cpu_cu
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ir,
    input  logic        N,
    input  logic        Z,
    input  logic        C,
    output logic        adr_sel,
    output logic        pc_sel,
    output logic        s_sel,
    output logic        pc_ld,
    output logic        pc_inc,
    output logic        reg_w_en,
    output logic        ir_ld,
    output logic [2:0]  W_Adr,
    output logic [2:0]  R_Adr,
    output logic [2:0]  S_Adr,
    output logic [3:0]  Alu_Op,
    output logic        mw_en,
    output logic        mr_en,
    output logic        halt,
    output logic        illegal,
    output logic [3:0]  state
);

    state_e   state_q, state_d;
    status_t  status_q, status_d;

    state_e   dec_exec_state;
    br_cond_e dec_br_cond;
    logic     dec_legal;

    cpu_cu_decode u_decode (
        .opcode     (ir[15:9]),
        .exec_state (dec_exec_state),
        .br_cond    (dec_br_cond),
        .legal      (dec_legal)
    );

    // State and status registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its pre-edge inputs regardless of statement order.
        if (!rst) begin
            state_q  <= ST_RESET;
            status_q <= '0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
        end
    end

    // Next-state and status-update logic.
    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        case (state_q)
            ST_RESET: begin
                status_d = '0;
                state_d  = ST_FETCH;
            end
            ST_FETCH: state_d = ST_DECODE;
            ST_DECODE: begin
                if (!dec_legal) begin
                    state_d = ST_ILLEGAL;
                end else if (dec_br_cond != BC_NONE) begin
                    state_d = br_taken(dec_br_cond, status_q) ? ST_BR_EX : ST_FETCH;
                end else begin
                    state_d = dec_exec_state;
                end
            end
            ST_ALU_EX: begin
                // Flags of this op become visible to an immediately following branch.
                status_d = '{n: N, z: Z, c: C};
                state_d  = ST_FETCH;
            end
            ST_LD_EX, ST_ST_EX, ST_LDI_EX,
            ST_BR_EX, ST_JMP_EX:   state_d = ST_FETCH;
            ST_HALT, ST_ILLEGAL:   state_d = state_q;
            // Unused encodings recover through a clean reset sequence.
            default:               state_d = ST_RESET;
        endcase
    end

    // Moore output decode; register addresses always mirror the IR fields.
    always_comb begin
        adr_sel  = 1'b0;
        pc_sel   = 1'b0;
        s_sel    = 1'b0;
        pc_ld    = 1'b0;
        pc_inc   = 1'b0;
        reg_w_en = 1'b0;
        ir_ld    = 1'b0;
        mw_en    = 1'b0;
        mr_en    = 1'b0;
        halt     = 1'b0;
        illegal  = 1'b0;
        Alu_Op   = ALU_PASS_S;
        case (state_q)
            ST_FETCH: begin
                mr_en  = 1'b1;
                ir_ld  = 1'b1;
                pc_inc = 1'b1;
            end
            ST_ALU_EX: begin
                reg_w_en = 1'b1;
                Alu_Op   = ir[12:9];
            end
            ST_LD_EX: begin
                adr_sel  = 1'b1;
                mr_en    = 1'b1;
                s_sel    = 1'b1;
                reg_w_en = 1'b1;
            end
            ST_ST_EX: begin
                adr_sel = 1'b1;
                mw_en   = 1'b1;
            end
            ST_LDI_EX: begin
                mr_en    = 1'b1;
                s_sel    = 1'b1;
                reg_w_en = 1'b1;
                pc_inc   = 1'b1;
            end
            ST_BR_EX: pc_ld = 1'b1;
            ST_JMP_EX: begin
                pc_sel = 1'b1;
                pc_ld  = 1'b1;
            end
            ST_HALT: halt = 1'b1;
            ST_ILLEGAL: begin
                halt    = 1'b1;
                illegal = 1'b1;
            end
            default: ;
        endcase
    end

    assign W_Adr = ir[8:6];
    assign R_Adr = ir[5:3];
    assign S_Adr = ir[2:0];
    assign state = state_q;

endmodule

// File: tb/tb_cpu_cu.sv
// Self-checking bench for cpu_cu: directed scenarios plus a randomized
// instruction stream compared against an instruction-level reference model.
module tb_cpu_cu;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] ir  = '0;
    logic        N = 1'b0, Z = 1'b0, C = 1'b0;
    logic        adr_sel, pc_sel, s_sel, pc_ld, pc_inc, reg_w_en, ir_ld;
    logic [2:0]  W_Adr, R_Adr, S_Adr;
    logic [3:0]  Alu_Op;
    logic        mw_en, mr_en, halt, illegal;
    logic [3:0]  state;

    int tests_run = 0;
    int failed    = 0;

    cpu_cu dut (
        .clk(clk), .rst(rst), .ir(ir), .N(N), .Z(Z), .C(C),
        .adr_sel(adr_sel), .pc_sel(pc_sel), .s_sel(s_sel), .pc_ld(pc_ld),
        .pc_inc(pc_inc), .reg_w_en(reg_w_en), .ir_ld(ir_ld),
        .W_Adr(W_Adr), .R_Adr(R_Adr), .S_Adr(S_Adr), .Alu_Op(Alu_Op),
        .mw_en(mw_en), .mr_en(mr_en), .halt(halt), .illegal(illegal),
        .state(state)
    );

    always #5 clk = ~clk;

    logic [14:0] obs_ctrl;
    assign obs_ctrl = {adr_sel, pc_sel, s_sel, pc_ld, pc_inc, reg_w_en, ir_ld,
                       mw_en, mr_en, halt, illegal, Alu_Op};

    // Expected control vector per state number, straight from the state table.
    function automatic logic [14:0] model_ctrl(int st, logic [15:0] irv);
        logic adr, pcs, ss, pcl, pci, rw, irl, mw, mr, h, il;
        logic [3:0] op;
        {adr, pcs, ss, pcl, pci, rw, irl, mw, mr, h, il} = '0;
        op = 4'h0;
        case (st)
            1:  begin mr = 1; irl = 1; pci = 1; end
            3:  begin rw = 1; op = irv[12:9]; end
            4:  begin adr = 1; mr = 1; ss = 1; rw = 1; end
            5:  begin adr = 1; mw = 1; end
            6:  begin mr = 1; ss = 1; rw = 1; pci = 1; end
            7:  pcl = 1;
            8:  begin pcs = 1; pcl = 1; end
            9:  h = 1;
            10: begin h = 1; il = 1; end
            default: ;
        endcase
        return {adr, pcs, ss, pcl, pci, rw, irl, mw, mr, h, il, op};
    endfunction

    // State reached after DECODE for an opcode, given latched flags {N,Z,C}.
    function automatic int model_next(int op, logic [2:0] st);
        if (op == 'h00) return 1;
        if (op >= 'h10 && op <= 'h1F) return 3;
        case (op)
            'h20: return 4;
            'h21: return 5;
            'h22: return 6;
            'h30: return 7;
            'h31: return st[1] ? 7 : 1;
            'h32: return st[1] ? 1 : 7;
            'h33: return st[2] ? 7 : 1;
            'h34: return st[0] ? 7 : 1;
            'h38: return 8;
            'h7F: return 9;
            default: return 10;
        endcase
    endfunction

    function automatic logic [15:0] gen_ir();
        logic [6:0] op;
        case ($urandom_range(0, 15))
            0:        op = 7'h00;
            1, 2, 3:  op = {3'b001, 4'($urandom_range(0, 15))};
            4:        op = 7'h20;
            5:        op = 7'h21;
            6:        op = 7'h22;
            7:        op = 7'h30;
            8:        op = 7'h31;
            9:        op = 7'h32;
            10:       op = 7'h33;
            11:       op = 7'h34;
            12:       op = 7'h38;
            13:       op = ($urandom_range(0, 3) == 0) ? 7'h7F : 7'h15;
            14:       op = 7'($urandom);
            default:  op = {3'b001, 4'($urandom_range(0, 15))};
        endcase
        return {op, 9'($urandom)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; ir = 16'h0000; {N, Z, C} = 3'b000;
        repeat (3) tick();
        tests_run++; if (state !== 4'd0) begin failed++; $display("FAIL reset_state got %0d want 0", state); end
        tests_run++; if (obs_ctrl !== 15'h0) begin failed++; $display("FAIL reset_ctrl got %h want 0", obs_ctrl); end
        tests_run++; if (halt !== 1'b0) begin failed++; $display("FAIL reset_halt got %b want 0", halt); end
        rst = 1'b1;
        tick();
        tests_run++; if (state !== 4'd1) begin failed++; $display("FAIL release_state got %0d want 1", state); end
        tests_run++; if ({ir_ld, mr_en, pc_inc} !== 3'b111) begin failed++; $display("FAIL release_fetch got %b want 111", {ir_ld, mr_en, pc_inc}); end
    endtask

    task automatic test_alu();
        ir = 16'h2A53; {N, Z, C} = 3'b010;
        tick();
        tests_run++; if (state !== 4'd2 || reg_w_en !== 1'b0) begin failed++; $display("FAIL alu_decode got st=%0d rw=%b want st=2 rw=0", state, reg_w_en); end
        tick();
        tests_run++; if (state !== 4'd3 || reg_w_en !== 1'b1) begin failed++; $display("FAIL alu_exec got st=%0d rw=%b want st=3 rw=1", state, reg_w_en); end
        tests_run++; if (W_Adr !== 3'd1 || Alu_Op !== 4'd5) begin failed++; $display("FAIL alu_fields got W=%0d op=%0d want W=1 op=5", W_Adr, Alu_Op); end
        tick();
        {N, Z, C} = 3'b000;
        tests_run++; if (state !== 4'd1 || reg_w_en !== 1'b0) begin failed++; $display("FAIL alu_back got st=%0d rw=%b want st=1 rw=0", state, reg_w_en); end
        ir = 16'h6200;
        tick(); tick();
        tests_run++; if (state !== 4'd7 || pc_ld !== 1'b1) begin failed++; $display("FAIL beq_after_alu got st=%0d pc_ld=%b want st=7 pc_ld=1", state, pc_ld); end
        tick();
    endtask

    task automatic test_load_store();
        ir = 16'h4050;
        tick(); tick();
        tests_run++; if (state !== 4'd4 || {adr_sel, mr_en, reg_w_en} !== 3'b111) begin failed++; $display("FAIL ld_exec got st=%0d ctl=%b want st=4 ctl=111", state, {adr_sel, mr_en, reg_w_en}); end
        tick();
        ir = 16'h4213;
        tick(); tick();
        tests_run++; if (state !== 4'd5 || {mw_en, mr_en, reg_w_en} !== 3'b100) begin failed++; $display("FAIL st_exec got st=%0d ctl=%b want st=5 ctl=100", state, {mw_en, mr_en, reg_w_en}); end
        tick();
        tests_run++; if (state !== 4'd1) begin failed++; $display("FAIL st_back got %0d want 1", state); end
    endtask

    task automatic test_branch();
        ir = 16'h2A53; {N, Z, C} = 3'b010;
        repeat (3) tick();
        {N, Z, C} = 3'b000;
        ir = 16'h64F0;
        tick();
        tests_run++; if (state !== 4'd2 || pc_ld !== 1'b0) begin failed++; $display("FAIL bne_nt_decode got st=%0d pc_ld=%b want st=2 pc_ld=0", state, pc_ld); end
        tick();
        tests_run++; if (state !== 4'd1 || pc_ld !== 1'b0) begin failed++; $display("FAIL bne_nt_fetch got st=%0d pc_ld=%b want st=1 pc_ld=0", state, pc_ld); end
        ir = 16'h2A53;
        repeat (3) tick();
        ir = 16'h64F0;
        tick(); tick();
        tests_run++; if (state !== 4'd7 || pc_ld !== 1'b1 || pc_sel !== 1'b0) begin failed++; $display("FAIL bne_taken got st=%0d pc_ld=%b pc_sel=%b want 7 1 0", state, pc_ld, pc_sel); end
        tick();
    endtask

    task automatic test_terminal();
        ir = 16'hFE00;
        tick(); tick();
        tests_run++; if (state !== 4'd9 || halt !== 1'b1 || illegal !== 1'b0) begin failed++; $display("FAIL halt_enter got st=%0d halt=%b ill=%b want 9 1 0", state, halt, illegal); end
        for (int i = 0; i < 10; i++) begin
            ir = 16'($urandom);
            tick();
            tests_run++; if (state !== 4'd9 || halt !== 1'b1) begin failed++; $display("FAIL halt_hold cycle %0d got st=%0d halt=%b want 9 1", i, state, halt); end
        end
        rst = 1'b0; tick();
        tests_run++; if (state !== 4'd0 || halt !== 1'b0) begin failed++; $display("FAIL halt_reset got st=%0d halt=%b want 0 0", state, halt); end
        rst = 1'b1; tick();
        ir = 16'h0E00;
        tick(); tick();
        tests_run++; if (state !== 4'd10 || illegal !== 1'b1 || halt !== 1'b1) begin failed++; $display("FAIL illegal_enter got st=%0d ill=%b halt=%b want 10 1 1", state, illegal, halt); end
        ir = 16'h0000; tick();
        tests_run++; if (state !== 4'd10) begin failed++; $display("FAIL illegal_hold got %0d want 10", state); end
        rst = 1'b0; tick();
        tests_run++; if (state !== 4'd0 || illegal !== 1'b0) begin failed++; $display("FAIL illegal_reset got st=%0d ill=%b want 0 0", state, illegal); end
        rst = 1'b1; tick();
    endtask

    task automatic test_reset_mid_op();
        ir = 16'h2A53; {N, Z, C} = 3'b010;
        repeat (3) tick();
        {N, Z, C} = 3'b000;
        ir = 16'h4213;
        tick(); tick();
        tests_run++; if (state !== 4'd5 || mw_en !== 1'b1) begin failed++; $display("FAIL midop_store got st=%0d mw=%b want 5 1", state, mw_en); end
        rst = 1'b0;
        #1;
        tests_run++; if (mw_en !== 1'b1) begin failed++; $display("FAIL midop_store_held got mw=%b want 1", mw_en); end
        tick();
        tests_run++; if (state !== 4'd0 || mw_en !== 1'b0) begin failed++; $display("FAIL midop_reset got st=%0d mw=%b want 0 0", state, mw_en); end
        rst = 1'b1; tick();
        ir = 16'h6200;
        tick(); tick();
        tests_run++; if (state !== 4'd1) begin failed++; $display("FAIL midop_status_clear got st=%0d want 1 (BEQ not taken)", state); end
    endtask

    task automatic test_random();
        logic [2:0]  status_m;
        logic [15:0] irv;
        int          cur;
        int          seq[$];
        rst = 1'b0; tick(); rst = 1'b1; tick();
        status_m = 3'b000;
        cur = 1;
        for (int n = 0; n < 200; n++) begin
            irv = gen_ir();
            ir  = irv;
            #1;
            tests_run++; if (obs_ctrl !== model_ctrl(cur, irv) || state !== 4'(cur)) begin failed++; $display("FAIL rnd_fetch ir=%h got st=%0d ctl=%h want st=%0d ctl=%h", irv, state, obs_ctrl, cur, model_ctrl(cur, irv)); end
            seq.delete();
            seq.push_back(2);
            begin
                int e;
                e = model_next(int'(irv[15:9]), status_m);
                if (e != 1) seq.push_back(e);
                if (e < 9) seq.push_back(1);
                else repeat (2) seq.push_back(e);
            end
            foreach (seq[k]) begin
                {N, Z, C} = 3'($urandom);
                if (cur == 3) status_m = {N, Z, C};
                tick();
                cur = seq[k];
                tests_run++; if (state !== 4'(cur)) begin failed++; $display("FAIL rnd_state ir=%h got %0d want %0d", irv, state, cur); end
                tests_run++; if (obs_ctrl !== model_ctrl(cur, irv)) begin failed++; $display("FAIL rnd_ctrl ir=%h st=%0d got %h want %h", irv, cur, obs_ctrl, model_ctrl(cur, irv)); end
                tests_run++; if ({W_Adr, R_Adr, S_Adr} !== irv[8:0]) begin failed++; $display("FAIL rnd_addr ir=%h got %h want %h", irv, {W_Adr, R_Adr, S_Adr}, irv[8:0]); end
            end
            if (cur >= 9) begin
                rst = 1'b0; tick();
                status_m = 3'b000;
                tests_run++; if (state !== 4'd0 || obs_ctrl !== 15'h0) begin failed++; $display("FAIL rnd_reset got st=%0d ctl=%h want 0 0", state, obs_ctrl); end
                rst = 1'b1; tick();
                cur = 1;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_alu();
        test_load_store();
        test_branch();
        test_terminal();
        test_reset_mid_op();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
